// File: rtl/trace_capture_unit_if.sv
// Signal bundle between the trace capture unit and its controller/observer.
// The master side drives control, capture taps and read requests; the slave side returns status and read data.
interface trace_capture_unit_if #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
);
  logic              arm;
  logic              stop;
  logic [PC_W-1:0]   trig_pc;
  logic [AW:0]       post_count;
  logic              cap_valid;
  logic [PC_W-1:0]   cap_pc;
  logic [REG_W-1:0]  cap_reg;
  logic [DATA_W-1:0] cap_data;
  logic              rd_en;
  logic [AW-1:0]     rd_idx;
  logic              rd_valid;
  logic [PC_W-1:0]   rd_pc;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        state;
  logic [AW:0]       entry_count;
  logic              trig_hit;

  modport master (
    output arm, stop, trig_pc, post_count, cap_valid, cap_pc, cap_reg, cap_data, rd_en, rd_idx,
    input  rd_valid, rd_pc, rd_reg, rd_data, state, entry_count, trig_hit
  );

  modport slave (
    input  arm, stop, trig_pc, post_count, cap_valid, cap_pc, cap_reg, cap_data, rd_en, rd_idx,
    output rd_valid, rd_pc, rd_reg, rd_data, state, entry_count, trig_hit
  );
endinterface

// File: rtl/trace_capture_unit.sv
// Circular trace buffer of register-file writebacks with a PC-match trigger,
// a clamped post-trigger window, and indexed readback once capture is frozen.
module trace_capture_unit #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  trace_capture_unit_if.slave  io_trace
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRIG  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int            WORD_W   = PC_W + REG_W + DATA_W;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [AW-1:0] MAX_POST = AW'(DEPTH - 1);

  state_t            r_state, w_state_next;
  logic [AW-1:0]     r_wr_ptr, w_wr_ptr_next;
  logic [AW:0]       r_entry_count, w_entry_count_next;
  logic [AW-1:0]     r_post_cnt, w_post_cnt_next;
  logic              r_trig_hit, w_trig_hit_next;
  logic              r_rd_valid, r_rd_ok;
  logic [WORD_W-1:0] r_rd_word;
  logic [WORD_W-1:0] r_mem [DEPTH];

  logic              w_capturing, w_wr_en, w_trig_fire, w_rd_ok;
  logic [AW-1:0]     w_post_clamped, w_rd_addr;

  assign w_capturing = (r_state == S_ARMED) || (r_state == S_TRIG);
  // A restart discards whatever capture strobe arrives with it.
  assign w_wr_en     = io_trace.cap_valid && w_capturing && !io_trace.arm;
  assign w_trig_fire = w_wr_en && (r_state == S_ARMED) && (io_trace.cap_pc == io_trace.trig_pc);
  // Clamp to DEPTH-1 so the trigger entry survives the post window.
  assign w_post_clamped = (io_trace.post_count >= DEPTH_C) ? MAX_POST : io_trace.post_count[AW-1:0];

  always_comb begin
    w_state_next       = r_state;
    w_wr_ptr_next      = r_wr_ptr;
    w_entry_count_next = r_entry_count;
    w_post_cnt_next    = r_post_cnt;
    w_trig_hit_next    = r_trig_hit;
    if (io_trace.arm) begin
      w_state_next       = S_ARMED;
      w_wr_ptr_next      = '0;
      w_entry_count_next = '0;
      w_post_cnt_next    = '0;
      w_trig_hit_next    = 1'b0;
    end else begin
      if (w_wr_en) begin
        w_wr_ptr_next = r_wr_ptr + ONE_A;
        if (r_entry_count != DEPTH_C) begin
          w_entry_count_next = r_entry_count + ONE_C;
        end
      end
      case (r_state)
        S_ARMED: begin
          if (w_trig_fire) begin
            w_trig_hit_next = 1'b1;
            w_post_cnt_next = w_post_clamped;
            w_state_next    = (w_post_clamped == '0 || io_trace.stop) ? S_DONE : S_TRIG;
          end else if (io_trace.stop) begin
            w_state_next = S_DONE;
          end
        end
        S_TRIG: begin
          if (w_wr_en) begin
            w_post_cnt_next = r_post_cnt - ONE_A;
          end
          if (io_trace.stop || (w_wr_en && r_post_cnt == ONE_A)) begin
            w_state_next = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_entry_count <= '0;
      r_post_cnt    <= '0;
      r_trig_hit    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_ok       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_wr_ptr      <= w_wr_ptr_next;
      r_entry_count <= w_entry_count_next;
      r_post_cnt    <= w_post_cnt_next;
      r_trig_hit    <= w_trig_hit_next;
      r_rd_valid    <= io_trace.rd_en;
      r_rd_ok       <= io_trace.rd_en && w_rd_ok;
    end
  end

  // Index 0 is the oldest entry; a full buffer makes the subtraction vanish mod DEPTH.
  assign w_rd_addr = r_wr_ptr - r_entry_count[AW-1:0] + io_trace.rd_idx;
  assign w_rd_ok   = (r_state == S_DONE) && ({1'b0, io_trace.rd_idx} < r_entry_count);

  // Storage carries no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge i_clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {io_trace.cap_pc, io_trace.cap_reg, io_trace.cap_data};
    end
    if (io_trace.rd_en) begin
      r_rd_word <= r_mem[w_rd_addr];
    end
  end

  assign io_trace.rd_valid    = r_rd_valid;
  assign io_trace.rd_pc       = r_rd_ok ? r_rd_word[WORD_W-1 -: PC_W]  : '0;
  assign io_trace.rd_reg      = r_rd_ok ? r_rd_word[DATA_W +: REG_W]   : '0;
  assign io_trace.rd_data     = r_rd_ok ? r_rd_word[DATA_W-1:0]        : '0;
  assign io_trace.state       = r_state;
  assign io_trace.entry_count = r_entry_count;
  assign io_trace.trig_hit    = r_trig_hit;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Self-checking bench for trace_capture_unit: read responses are scoreboarded,
// status outputs are checked directly after each stimulus step.
module tb_trace_capture_unit;
  localparam int PC_W   = 16;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  rd_exp_t exp_q[$];
  rd_exp_t mon_e;

  trace_capture_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .AW(AW)) tb_if ();

  trace_capture_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io_trace  (tb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read responses are matched in order against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n && tb_if.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("rd_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("read: pc=0x%04h reg=%0d data=0x%04h", tb_if.rd_pc, tb_if.rd_reg, tb_if.rd_data);
        check_val("rd_pc", 64'(tb_if.rd_pc), 64'(mon_e.pc));
        check_val("rd_reg", 64'(tb_if.rd_reg), 64'(mon_e.rg));
        check_val("rd_data", 64'(tb_if.rd_data), 64'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [15:0] tpc, input logic [4:0] post);
    tb_if.arm        = 1'b1;
    tb_if.trig_pc    = tpc;
    tb_if.post_count = post;
    tick();
    tb_if.arm = 1'b0;
    $display("arm: trig_pc=0x%04h post=%0d", tpc, post);
  endtask

  task automatic do_stop();
    tb_if.stop = 1'b1;
    tick();
    tb_if.stop = 1'b0;
    $display("stop: state=%0d count=%0d", tb_if.state, tb_if.entry_count);
  endtask

  task automatic cap(input logic [15:0] pc, input logic [15:0] data);
    tb_if.cap_valid = 1'b1;
    tb_if.cap_pc    = pc;
    tb_if.cap_reg   = pc[2:0];
    tb_if.cap_data  = data;
    tick();
    tb_if.cap_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [15:0] epc, input logic [2:0] erg,
                    input logic [15:0] edata);
    rd_exp_t e;
    e.pc   = epc;
    e.rg   = erg;
    e.data = edata;
    exp_q.push_back(e);
    tb_if.rd_en  = 1'b1;
    tb_if.rd_idx = idx;
    tick();
    tb_if.rd_en = 1'b0;
    check_val("rd_valid_latency", 64'(tb_if.rd_valid), 64'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5) begin
      tick();
      k++;
    end
    check_val("rd_drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [15:0] dfun(input logic [15:0] pc);
    return pc ^ 16'hA5A5;
  endfunction

  initial begin
    logic [15:0] pc;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    tb_if.arm = 1'b0; tb_if.stop = 1'b0; tb_if.trig_pc = '0; tb_if.post_count = '0;
    tb_if.cap_valid = 1'b0; tb_if.cap_pc = '0; tb_if.cap_reg = '0; tb_if.cap_data = '0;
    tb_if.rd_en = 1'b0; tb_if.rd_idx = '0;
    #2;
    check_val("rst_state", 64'(tb_if.state), 64'd0);
    check_val("rst_count", 64'(tb_if.entry_count), 64'd0);
    check_val("rst_trig", 64'(tb_if.trig_hit), 64'd0);
    check_val("rst_rd_valid", 64'(tb_if.rd_valid), 64'd0);
    check_val("rst_rd_pc", 64'(tb_if.rd_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Short capture, stop coinciding with the fifth write.
    do_arm(16'hFFFF, 5'd0);
    check_val("t1_armed", 64'(tb_if.state), 64'd1);
    for (int i = 0; i < 4; i++) cap(16'(i), 16'hDEA0 + 16'(i));
    rd(4'd0, 16'h0, 3'd0, 16'h0);
    tb_if.stop = 1'b1;
    cap(16'h0004, 16'hDEA4);
    tb_if.stop = 1'b0;
    check_val("t1_state", 64'(tb_if.state), 64'd3);
    check_val("t1_count", 64'(tb_if.entry_count), 64'd5);
    rd(4'd0, 16'h0000, 3'd0, 16'hDEA0);
    rd(4'd4, 16'h0004, 3'd4, 16'hDEA4);
    rd(4'd5, 16'h0000, 3'd0, 16'h0000);
    drain();

    // Wrap-around without trigger.
    do_arm(16'hFFFF, 5'd0);
    for (int i = 0; i < 20; i++) begin
      pc = 16'h0010 + 16'(i);
      cap(pc, dfun(pc));
    end
    do_stop();
    check_val("t2_count", 64'(tb_if.entry_count), 64'd16);
    check_val("t2_trig", 64'(tb_if.trig_hit), 64'd0);
    check_val("t2_state", 64'(tb_if.state), 64'd3);
    rd(4'd0, 16'h0014, 3'd4, dfun(16'h0014));
    rd(4'd15, 16'h0023, 3'd3, dfun(16'h0023));
    drain();

    // Trigger with a 3-entry post window.
    do_arm(16'h0030, 5'd3);
    for (int i = 16'h20; i <= 16'h3F; i++) begin
      pc = 16'(i);
      cap(pc, dfun(pc));
      if (pc == 16'h0030) begin
        check_val("t3_trig_hit", 64'(tb_if.trig_hit), 64'd1);
        check_val("t3_state_trig", 64'(tb_if.state), 64'd2);
      end
      if (pc == 16'h0032) check_val("t3_state_32", 64'(tb_if.state), 64'd2);
      if (pc == 16'h0033) check_val("t3_state_33", 64'(tb_if.state), 64'd3);
    end
    check_val("t3_count", 64'(tb_if.entry_count), 64'd16);
    rd(4'd0, 16'h0024, 3'd4, dfun(16'h0024));
    rd(4'd12, 16'h0030, 3'd0, dfun(16'h0030));
    rd(4'd15, 16'h0033, 3'd3, dfun(16'h0033));
    drain();

    // Zero post window: the trigger write itself finishes capture.
    do_arm(16'h0030, 5'd0);
    for (int i = 16'h20; i <= 16'h3F; i++) begin
      pc = 16'(i);
      cap(pc, dfun(pc));
      if (pc == 16'h0030) check_val("t4a_state", 64'(tb_if.state), 64'd3);
    end
    check_val("t4a_count", 64'(tb_if.entry_count), 64'd16);
    rd(4'd15, 16'h0030, 3'd0, dfun(16'h0030));
    rd(4'd0, 16'h0021, 3'd1, dfun(16'h0021));
    drain();

    // Oversized post window clamps to DEPTH-1.
    do_arm(16'h0030, 5'd31);
    for (int i = 16'h20; i <= 16'h45; i++) begin
      pc = 16'(i);
      cap(pc, dfun(pc));
      if (pc == 16'h003E) check_val("t4b_state_3e", 64'(tb_if.state), 64'd2);
      if (pc == 16'h003F) check_val("t4b_state_3f", 64'(tb_if.state), 64'd3);
    end
    rd(4'd0, 16'h0030, 3'd0, dfun(16'h0030));
    rd(4'd15, 16'h003F, 3'd7, dfun(16'h003F));
    drain();

    // Asynchronous reset while triggered, with a read response in flight.
    do_arm(16'h0030, 5'd31);
    for (int i = 16'h28; i < 16'h30; i++) cap(16'(i), dfun(16'(i)));
    tb_if.rd_en  = 1'b1;
    tb_if.rd_idx = 4'd0;
    cap(16'h0030, dfun(16'h0030));
    tb_if.rd_en = 1'b0;
    check_val("t5_pre_state", 64'(tb_if.state), 64'd2);
    check_val("t5_pre_count", 64'(tb_if.entry_count), 64'd9);
    check_val("t5_pre_rd_valid", 64'(tb_if.rd_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-cycle");
    check_val("t5_state", 64'(tb_if.state), 64'd0);
    check_val("t5_count", 64'(tb_if.entry_count), 64'd0);
    check_val("t5_trig", 64'(tb_if.trig_hit), 64'd0);
    check_val("t5_rd_valid", 64'(tb_if.rd_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Stop and captures are ignored in IDLE; arm beats stop and clears the flag.
    tb_if.stop = 1'b1;
    cap(16'h0001, 16'h1111);
    tb_if.stop = 1'b0;
    check_val("t6_idle_state", 64'(tb_if.state), 64'd0);
    check_val("t6_idle_count", 64'(tb_if.entry_count), 64'd0);
    do_arm(16'h0050, 5'd0);
    cap(16'h0050, 16'h5050);
    check_val("t6_done", 64'(tb_if.state), 64'd3);
    check_val("t6_hit", 64'(tb_if.trig_hit), 64'd1);
    tb_if.arm  = 1'b1;
    tb_if.stop = 1'b1;
    tick();
    tb_if.arm  = 1'b0;
    tb_if.stop = 1'b0;
    $display("arm+stop: state=%0d count=%0d", tb_if.state, tb_if.entry_count);
    check_val("t6_rearm_state", 64'(tb_if.state), 64'd1);
    check_val("t6_rearm_count", 64'(tb_if.entry_count), 64'd0);
    check_val("t6_rearm_hit", 64'(tb_if.trig_hit), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/trace_capture_unit.md
Name: trace_capture_unit

Overview:
- Parametrised on-chip trace buffer for the 16-bit multicycle processor.
- Records register-file writeback events (PC, destination register, write data) into a circular buffer, with a PC-match trigger and a post-trigger capture window.
- Sits beside TopLevel and taps PC, regWrite, writeReg and writeFile.
- Captured history is read back by index after the capture stops.

Parameters:
- PC_W, 16, width of captured PC.
- DATA_W, 16, width of captured write data.
- REG_W, 3, width of destination register number.
- DEPTH, 16, buffer entries; power of two, >= 2.
- AW, log2(DEPTH), index width (derived).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse; clears the buffer and starts capture.
- stop  in  1  single-cycle pulse; freezes the buffer.
- trig_pc  in  PC_W  PC value that fires the trigger.
- post_count  in  AW+1  entries to capture after the trigger entry.
- cap_valid  in  1  writeback strobe (regWrite).
- cap_pc  in  PC_W  PC of the writing instruction.
- cap_reg  in  REG_W  destination register.
- cap_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_idx  in  AW  read index; 0 = oldest entry.
- rd_valid  out  1  read response strobe.
- rd_pc  out  PC_W  read PC field.
- rd_reg  out  REG_W  read register field.
- rd_data  out  DATA_W  read data field.
- state  out  2  capture state: 0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE.
- entry_count  out  AW+1  valid entries, saturates at DEPTH.
- trig_hit  out  1  sticky trigger flag.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, write pointer=0, entry_count=0, post counter=0, trig_hit=0, rd_valid=0, rd_pc/rd_reg/rd_data=0. Buffer storage is not reset; entry_count=0 makes it don't-care. Reset mid-capture aborts immediately.
- IDLE:
  - arm -> ARMED; write pointer and entry_count clear to 0; trig_hit clears.
  - cap_valid and stop are ignored.
- ARMED:
  - Each cap_valid writes {cap_pc, cap_reg, cap_data} at the write pointer.
  - The write pointer increments modulo DEPTH (wrap-around overwrites the oldest entry).
  - entry_count increments, saturating at DEPTH.
  - If cap_valid && cap_pc==trig_pc: the entry is stored as normal and trig_hit=1.
    - Post counter loads min(post_count, DEPTH-1). The clamp guarantees the trigger entry is never overwritten.
    - Next state is TRIGGERED, or DONE if the clamped value is 0.
- TRIGGERED:
  - Each cap_valid stores an entry as in ARMED and decrements the post counter.
  - The write that takes the counter to 0 moves to DONE.
  - The trigger comparison is not evaluated.
- DONE: buffer frozen; cap_valid ignored.
- stop in ARMED or TRIGGERED -> DONE next edge. A cap_valid in the same cycle is still stored.
- arm in any non-IDLE state restarts, exactly as arm from IDLE.
- arm and stop in the same cycle: arm wins.
- Readout:
  - rd_en sampled at an edge produces rd_valid=1 on the following cycle, with registered rd_* (1-cycle latency). rd_valid is 0 otherwise.
  - Physical address = (wr_ptr - entry_count + rd_idx) mod DEPTH.
  - If state!=DONE or rd_idx>=entry_count: rd_valid still pulses, rd_pc/rd_reg/rd_data=0.
  - Back-to-back rd_en is allowed, one response per cycle.
- All pointer and counter arithmetic is unsigned, modulo DEPTH for pointers. entry_count never exceeds DEPTH.

Test Plan:
- Arm (trig_pc=0xFFFF); 5 cap_valid with pc 0x0000..0x0004, data 0xDEA0..0xDEA4; stop -> state=3, entry_count=5; rd_idx=0 gives pc 0x0000/data 0xDEA0 one cycle after rd_en; rd_idx=5 gives rd_valid=1 with zeros.
- Arm (trig_pc=0xFFFF); 20 captures pc 0x0010..0x0023; stop -> entry_count=16, trig_hit=0; rd_idx=0 -> pc 0x0014; rd_idx=15 -> pc 0x0023.
- Arm (trig_pc=0x0030, post_count=3); captures pc 0x0020..0x003F continuous -> trig_hit=1 at 0x0030; state=DONE after 0x0033 is stored; entry_count=16; rd_idx=0 -> 0x0024; rd_idx=12 -> 0x0030; later captures not stored.
- post_count=0 and post_count=31 (clamped to 15): trigger at 0x0030 -> DONE on the trigger write, rd_idx=15 -> 0x0030; clamped case: DONE after 15 further entries, rd_idx=0 -> 0x0030.
- reset_n low while TRIGGERED with entry_count=9 -> state=0, entry_count=0, trig_hit=0, rd_valid=0 immediately, without waiting for a clock edge.
- arm and stop asserted in the same cycle from DONE -> state=ARMED, entry_count=0; stop alone in IDLE -> state stays IDLE.
